// File: rtl/sipo_pkg.sv
// sipo_pkg: shared constants and helpers for the serial-in/parallel-out family
package sipo_pkg;

    localparam bit SIPO_LSB_FIRST = 1'b0;
    localparam bit SIPO_MSB_FIRST = 1'b1;

    // Smallest r with 2**r >= v; usable in parameter expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// sipo_out_slot: one-entry valid/ready holding register for assembled words
module sipo_out_slot
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             consume,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid
);

    // Load wins over consume so a completion in the consume cycle streams without a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_out   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            par_out   <= word;
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_stream.sv
// sipo_stream: serial-in/parallel-out deserialiser with valid/ready on both sides
module sipo_stream
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = SIPO_MSB_FIRST,
    parameter int CW        = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             serial_in,
    output logic             in_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic             last;
    logic             accept;

    assign last      = bit_cnt == CW'(WIDTH - 1);
    assign in_ready  = !last || !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign next_word = (MSB_FIRST == SIPO_MSB_FIRST) ? {shift_reg[WIDTH-2:0], serial_in}
                                                     : {serial_in, shift_reg[WIDTH-1:1]};

    // Collect bits; the completing bit hands the word to the slot and restarts assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (flush) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= last ? '0 : next_word;
            bit_cnt   <= last ? '0 : bit_cnt + CW'(1);
        end
    end

    sipo_out_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && last),
        .word      (next_word),
        .consume   (out_ready),
        .par_out   (par_out),
        .out_valid (out_valid)
    );

endmodule

// File: doc/sipo_stream.md
# sipo_stream

Parametrised serial-in/parallel-out deserialiser with valid/ready flow control on both sides. It assembles WIDTH serial bits, in a selectable bit order, into a parallel word. It holds that word in an output register until downstream accepts it, and it collects the next word meanwhile. It sits between bit-serial front ends (serial links, shift-chain readout) and word-wide datapath consumers.

## Interface
Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..64
- MSB_FIRST, 1, 1: first received bit ends in par_out[WIDTH-1]; 0: first bit ends in par_out[0]
- CW, clog2(WIDTH), bit counter width; derived, not overridden

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous discard of the partially assembled word
- in_valid  in  1  serial_in carries a valid bit this cycle
- serial_in  in  1  serial data bit
- in_ready  out  1  block accepts a bit this cycle
- par_out  out  WIDTH  assembled word, registered
- out_valid  out  1  par_out holds an unconsumed word
- out_ready  in  1  downstream consumes par_out this cycle
- bit_cnt  out  CW  bits collected in the current partial word, 0..WIDTH-1

## Operation
- Bit accept: in_valid && in_ready && !flush at the clock edge.
- Shift register behaviour by bit order:
  - MSB_FIRST=1: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: shift_reg <= {serial_in, shift_reg[WIDTH-1:1]}.
- Counter: bit_cnt increments on each accept. On the accept with bit_cnt==WIDTH-1, the completed word (shift_reg combined with the current bit) loads par_out, out_valid sets, and bit_cnt and shift_reg return to 0.
- Output consume: out_valid && out_ready clears out_valid. par_out keeps its value and is not cleared.
- in_ready = (bit_cnt != WIDTH-1) || !out_valid || out_ready. Only the completing bit is back-pressured. Bits 0..WIDTH-2 are always accepted while out_valid is held.
- Completion and consume in the same cycle: the new word loads and out_valid stays 1, giving zero-bubble streaming.
- flush=1: bit_cnt and shift_reg go to 0 and any bit presented that cycle is discarded. par_out and out_valid are unaffected, and a consume in the same cycle proceeds normally.
- Reset, including reset mid-word: shift_reg=0, bit_cnt=0, par_out=0, out_valid=0. The partial word is lost.
- Reset values of outputs: par_out=0, out_valid=0, bit_cnt=0. in_ready=1 after reset because out_valid=0.

## Timing
- Latency: out_valid rises on the edge that samples the WIDTH-th bit. The word is visible in the following cycle.
- Throughput: one bit per cycle sustained when out_ready is 1 or is asserted at least once per WIDTH cycles.
- in_ready depends combinationally on out_ready. This path is documented and intentional; no combinational path runs from serial_in or in_valid to any output.
- par_out, out_valid and bit_cnt are direct flop outputs.

## Structure
- Shared package sipo_pkg holds:
  - clog2 function
  - bit-order constants SIPO_LSB_FIRST=0 and SIPO_MSB_FIRST=1
- Sub-module sipo_out_slot is a one-entry valid/ready holding register (load, consume, par_out/out_valid flops). It is reused later by wider multi-lane variants.
- The top level contains the shift register, bit counter, in_ready logic and flush handling.

## Test plan
- Bit order, MSB_FIRST=1, WIDTH=8, out_ready=1: serial 1,0,1,0,0,1,0,1 on consecutive cycles -> par_out=8'hA5 and out_valid=1 for exactly one cycle after the 8th bit edge. Same stream with MSB_FIRST=0 -> 8'hA5 bit-reversed, 8'hA5 → 8'hA5 reversed = 8'hA5 is palindromic, so use 1,1,0,0,0,0,0,0 -> 8'h03.
- Back-pressure: out_ready=0 with two words 8'h3C then 8'hC3 streamed:
  - First word is held and in_ready drops only while bit_cnt==7.
  - Raising out_ready releases 8'hC3 the next cycle.
  - No bit is lost or duplicated.
- Zero-bubble streaming: 4 back-to-back words with out_ready=1 -> out_valid pulses every 8 cycles and values match the sent words in order.
- Flush mid-word: 3 bits sent, flush=1 with in_valid=1, then 8 bits of 8'h5A -> par_out=8'h5A and the pre-flush bits never appear. flush while out_valid=1 leaves the held word intact.
- Reset mid-operation: async rst pulsed between edges at bit_cnt=5 with out_valid=1 -> all outputs 0 immediately, and the next 8 bits form a correct new word.
- Parameter sweep: WIDTH=2 and WIDTH=64 with random streams and random out_ready -> scoreboard match, and bit_cnt never exceeds WIDTH-1.
